// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg: FSM encodings, latency defaults and lane
// bundle types shared by the MEM-stage controller and hazard unit.
package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    REPLAY = 2'd2
  } mem_state_t;

  localparam int MISS_LAT_DEF = 8;
  localparam int WB_PEN_DEF   = 4;
  localparam int CNT_W_DEF    = 5;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } mem_lane_t;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [29:0] wa;
  } hz_lane_t;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [1:0]  b
  );
    logic [32:0] s;
    s = {1'b0, a} + {31'd0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_hazard_chk.sv
// mem_hazard_chk: combinational intra-bundle hazard detection
// on word address (store-store suppress, store-load forward).
module mem_hazard_chk
  import mem_stage_ctrl_pkg::*;
(
  input  hz_lane_t l0,
  input  hz_lane_t l1,
  output logic     same_word,
  output logic     ss_sup,
  output logic     sl_fwd
);

  // Compare word addresses and classify the lane pair
  always_comb begin
    same_word = (l0.wa == l1.wa);
    ss_sup    = 1'b0;
    sl_fwd    = 1'b0;
    if (l0.v && l1.v && same_word) begin
      ss_sup = l0.we && l1.we;
      sl_fwd = l0.we && !l1.we;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: dual-lane load/store control with refill FSM.
// Optional perf counters enabled by MEMCTRL_PERF_EN.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int MISS_LAT = MISS_LAT_DEF,
  parameter int WB_PEN   = WB_PEN_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_v0,
  input  logic        req_we0,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_wd0,
  input  logic        req_v1,
  input  logic        req_we1,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wd1,
  output logic        c_re,
  output logic        c_re2,
  output logic        c_we,
  output logic        c_we2,
  output logic [31:0] c_addr,
  output logic [31:0] c_addr2,
  output logic [31:0] c_wd,
  output logic [31:0] c_wd2,
  input  logic        c_hit,
  input  logic        c_hit2,
  input  logic        c_miss,
  input  logic        c_miss2,
  input  logic        c_dirty,
  input  logic [31:0] c_rd,
  input  logic [31:0] c_rd2,
  output logic        stall,
  output logic        ld_v0,
  output logic        ld_v1,
  output logic [31:0] ld_data0,
  output logic [31:0] ld_data1
`ifdef MEMCTRL_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses,
  output logic [31:0] perf_stalls
`endif
);

  mem_state_t       state, nstate;
  logic [CNT_W-1:0] cnt;
  mem_lane_t        r0, r1, h0, h1, a0, a1;
  hz_lane_t         hz0, hz1;
  logic             same_word, ss_sup, sl_fwd;
  logic             issue, m0, m1, any_miss;
  logic             done, load_cnt;
  logic             ld0_go, ld1_go;

  assign r0 = {req_v0, req_we0, req_addr0, req_wd0};
  assign r1 = {req_v1, req_we1, req_addr1, req_wd1};

  assign a0 = (state == REPLAY) ? h0 : r0;
  assign a1 = (state == REPLAY) ? h1 : r1;

  assign hz0 = {a0.v, a0.we, a0.addr[31:2]};
  assign hz1 = {a1.v, a1.we, a1.addr[31:2]};

  mem_hazard_chk u_hz (
    .l0        (hz0),
    .l1        (hz1),
    .same_word (same_word),
    .ss_sup    (ss_sup),
    .sl_fwd    (sl_fwd)
  );

  // Forward and suppress only ever fire on a same-word pair
  always_comb begin
    assert (same_word || !(ss_sup || sl_fwd));
  end

  assign issue = !reset && (state != REFILL);

  assign c_re    = issue && a0.v && !a0.we;
  assign c_we    = issue && a0.v && a0.we && !ss_sup;
  assign c_re2   = issue && a1.v && !a1.we && !sl_fwd;
  assign c_we2   = issue && a1.v && a1.we;
  assign c_addr  = issue ? a0.addr : '0;
  assign c_addr2 = issue ? a1.addr : '0;
  assign c_wd    = issue ? a0.wd : '0;
  assign c_wd2   = issue ? a1.wd : '0;

  // A lane is resolved only on a positive hit
  assign m0 = a0.v && !ss_sup && (c_miss || !c_hit);
  assign m1 = a1.v && !sl_fwd && (c_miss2 || !c_hit2);
  assign any_miss = issue && (m0 || m1);

  // Next-state, stall and completion decode
  always_comb begin
    nstate   = state;
    stall    = 1'b0;
    done     = 1'b0;
    load_cnt = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_miss) begin
          stall    = 1'b1;
          load_cnt = 1'b1;
          nstate   = REFILL;
        end else begin
          done = 1'b1;
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (cnt == CNT_W'(1)) nstate = REPLAY;
      end
      REPLAY: begin
        stall = 1'b1;
        if (any_miss) begin
          load_cnt = 1'b1;
          nstate   = REFILL;
        end else begin
          done   = 1'b1;
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // Refill countdown, longer when the victim must be written back
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load_cnt) begin
      cnt <= c_dirty ? CNT_W'(MISS_LAT + WB_PEN)
                     : CNT_W'(MISS_LAT);
    end else if (state == REFILL) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Capture the missing bundle for replay
  always_ff @(posedge clk) begin
    if (reset) begin
      h0 <= '0;
      h1 <= '0;
    end else if (state == IDLE && load_cnt) begin
      h0 <= r0;
      h1 <= r1;
    end
  end

  assign ld0_go = done && a0.v && !a0.we;
  assign ld1_go = done && a1.v && !a1.we;

  // Register completed loads for WB
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_v0    <= 1'b0;
      ld_v1    <= 1'b0;
      ld_data0 <= '0;
      ld_data1 <= '0;
    end else begin
      ld_v0 <= ld0_go;
      ld_v1 <= ld1_go;
      if (ld0_go) ld_data0 <= c_rd;
      if (ld1_go) begin
        unique case (1'b1)
          sl_fwd:  ld_data1 <= a0.wd;
          default: ld_data1 <= c_rd2;
        endcase
      end
    end
  end

`ifdef MEMCTRL_PERF_EN
  logic hit0, hit1;

  assign hit0 = issue && a0.v && !ss_sup && !m0;
  assign hit1 = issue && a1.v && !sl_fwd && !m1;

  // Saturating hit, miss and stall-cycle counters
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_hits   <= '0;
      perf_misses <= '0;
      perf_stalls <= '0;
    end else begin
      if (done)
        perf_hits <= sat_add(perf_hits,
                             {1'b0, hit0} + {1'b0, hit1});
      if (load_cnt)
        perf_misses <= sat_add(perf_misses,
                               {1'b0, m0} + {1'b0, m1});
      if (stall)
        perf_stalls <= sat_add(perf_stalls, 2'd1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed hazard/refill scenarios plus
// randomized bundles checked against a timeline model.
module tb_mem_stage_ctrl;

  localparam int MISS_LAT = 8;
  localparam int WB_PEN   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_v0, req_we0, req_v1, req_we1;
  logic [31:0] req_addr0, req_wd0, req_addr1, req_wd1;
  logic        c_re, c_re2, c_we, c_we2;
  logic [31:0] c_addr, c_addr2, c_wd, c_wd2;
  logic        c_hit, c_hit2, c_miss, c_miss2, c_dirty;
  logic [31:0] c_rd, c_rd2;
  logic        stall, ld_v0, ld_v1;
  logic [31:0] ld_data0, ld_data1;
`ifdef MEMCTRL_PERF_EN
  logic [31:0] perf_hits, perf_misses, perf_stalls;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .MISS_LAT (MISS_LAT),
    .WB_PEN   (WB_PEN),
    .CNT_W    (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_v0    (req_v0),
    .req_we0   (req_we0),
    .req_addr0 (req_addr0),
    .req_wd0   (req_wd0),
    .req_v1    (req_v1),
    .req_we1   (req_we1),
    .req_addr1 (req_addr1),
    .req_wd1   (req_wd1),
    .c_re      (c_re),
    .c_re2     (c_re2),
    .c_we      (c_we),
    .c_we2     (c_we2),
    .c_addr    (c_addr),
    .c_addr2   (c_addr2),
    .c_wd      (c_wd),
    .c_wd2     (c_wd2),
    .c_hit     (c_hit),
    .c_hit2    (c_hit2),
    .c_miss    (c_miss),
    .c_miss2   (c_miss2),
    .c_dirty   (c_dirty),
    .c_rd      (c_rd),
    .c_rd2     (c_rd2),
    .stall     (stall),
    .ld_v0     (ld_v0),
    .ld_v1     (ld_v1),
    .ld_data0  (ld_data0),
    .ld_data1  (ld_data1)
`ifdef MEMCTRL_PERF_EN
    ,
    .perf_hits   (perf_hits),
    .perf_misses (perf_misses),
    .perf_stalls (perf_stalls)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(
    input logic v0, input logic we0,
    input logic [31:0] a0, input logic [31:0] d0,
    input logic v1, input logic we1,
    input logic [31:0] a1, input logic [31:0] d1
  );
    req_v0 = v0; req_we0 = we0;
    req_addr0 = a0; req_wd0 = d0;
    req_v1 = v1; req_we1 = we1;
    req_addr1 = a1; req_wd1 = d1;
  endtask

  task automatic set_resp(
    input logic h0, input logic m0,
    input logic h1, input logic m1, input logic dirty,
    input logic [31:0] rd0, input logic [31:0] rd1
  );
    c_hit = h0; c_miss = m0;
    c_hit2 = h1; c_miss2 = m1;
    c_dirty = dirty;
    c_rd = rd0; c_rd2 = rd1;
  endtask

  task automatic idle_in();
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    set_resp(1, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(1, 0, 32'h100, 5, 1, 1, 32'h200, 6);
    set_resp(0, 1, 0, 1, 1, 32'h77, 32'h88);
    step();
    step();
    n_chk++;
    if ({c_re, c_re2, c_we, c_we2, stall, ld_v0, ld_v1}
        !== 7'b0 || c_addr !== 0 || c_addr2 !== 0 ||
        c_wd !== 0 || c_wd2 !== 0 ||
        ld_data0 !== 0 || ld_data1 !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: ctl=%b a=%h/%h got nonzero, exp 0",
        {c_re, c_re2, c_we, c_we2, stall, ld_v0, ld_v1},
        c_addr, c_addr2);
    end
`ifdef MEMCTRL_PERF_EN
    n_chk++;
    if (perf_hits !== 0 || perf_misses !== 0 ||
        perf_stalls !== 0) begin
      n_fail++;
      $display("FAIL reset_perf: got %0d/%0d/%0d exp 0",
        perf_hits, perf_misses, perf_stalls);
    end
`endif
    reset = 1'b0;
    idle_in();
    step();
  endtask

  task automatic test_two_loads_hit();
    set_req(1, 0, 32'h100, 0, 1, 0, 32'h200, 0);
    set_resp(1, 0, 1, 0, 0, 32'hAAAA, 32'hBBBB);
    #1;
    n_chk++;
    if ({c_re, c_re2, c_we, c_we2} !== 4'b1100 ||
        c_addr !== 32'h100 || c_addr2 !== 32'h200) begin
      n_fail++;
      $display("FAIL ll_enables: got %b %h %h exp 1100 100 200",
        {c_re, c_re2, c_we, c_we2}, c_addr, c_addr2);
    end
    n_chk++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL ll_stall: got %b exp 0", stall);
    end
    step();
    n_chk++;
    if (ld_v0 !== 1 || ld_v1 !== 1 ||
        ld_data0 !== 32'hAAAA || ld_data1 !== 32'hBBBB) begin
      n_fail++;
      $display("FAIL ll_data: got %b%b %h %h exp 11 aaaa bbbb",
        ld_v0, ld_v1, ld_data0, ld_data1);
    end
    idle_in();
    step();
    n_chk++;
    if (ld_v0 !== 0 || ld_v1 !== 0) begin
      n_fail++;
      $display("FAIL ll_pulse: got %b%b exp 00", ld_v0, ld_v1);
    end
  endtask

  task automatic test_load_miss_clean();
    int stalls, pulses;
    logic [31:0] got;
    stalls = 0; pulses = 0; got = 0;
    set_req(1, 0, 32'h300, 0, 0, 0, 0, 0);
    set_resp(0, 1, 1, 1, 0, 32'hCAFE, 0);
    #1;
    for (int c = 0; c < 20; c++) begin
      if (stall) stalls++;
      step();
      if (ld_v0) begin
        pulses++;
        got = ld_data0;
      end
      set_req(0, 0, 0, 0, 0, 0, 0, 0);
      set_resp(1, 0, 1, 0, 0, 32'hCAFE, 0);
      #1;
    end
    n_chk++;
    if (stalls != 2 + MISS_LAT) begin
      n_fail++;
      $display("FAIL clean_stall_len: got %0d exp %0d",
        stalls, 2 + MISS_LAT);
    end
    n_chk++;
    if (pulses != 1 || got !== 32'hCAFE) begin
      n_fail++;
      $display("FAIL clean_ld: got %0d pulses %h exp 1 cafe",
        pulses, got);
    end
  endtask

  task automatic test_dirty_lane1();
    int stalls, pulses, first;
    logic [31:0] ra, got;
    stalls = 0; pulses = 0; first = -1; ra = 0; got = 0;
    set_req(0, 0, 0, 0, 1, 0, 32'h500, 0);
    set_resp(1, 0, 0, 1, 1, 0, 32'hD00D);
    #1;
    for (int c = 0; c < 25; c++) begin
      if (stall) stalls++;
      if (c > 0 && c_re2 && first < 0) begin
        first = c;
        ra = c_addr2;
      end
      step();
      if (ld_v1) begin
        pulses++;
        got = ld_data1;
      end
      set_req(0, 0, 0, 0, 0, 0, 0, 0);
      set_resp(1, 0, 1, 0, 0, 0, 32'hD00D);
      #1;
    end
    n_chk++;
    if (stalls != 2 + MISS_LAT + WB_PEN) begin
      n_fail++;
      $display("FAIL dirty_stall_len: got %0d exp %0d",
        stalls, 2 + MISS_LAT + WB_PEN);
    end
    n_chk++;
    if (first != 1 + MISS_LAT + WB_PEN || ra !== 32'h500) begin
      n_fail++;
      $display("FAIL dirty_replay: got cyc %0d addr %h exp %0d 500",
        first, ra, 1 + MISS_LAT + WB_PEN);
    end
    n_chk++;
    if (pulses != 1 || got !== 32'hD00D) begin
      n_fail++;
      $display("FAIL dirty_ld: got %0d %h exp 1 d00d", pulses, got);
    end
  endtask

  task automatic test_fwd();
    set_req(1, 1, 32'h40, 32'h1234, 1, 0, 32'h40, 0);
    set_resp(1, 0, 0, 1, 0, 0, 32'hDEAD);
    #1;
    n_chk++;
    if (c_we !== 1 || c_wd !== 32'h1234 || c_addr !== 32'h40 ||
        stall !== 0) begin
      n_fail++;
      $display("FAIL fwd_issue: got we=%b wd=%h st=%b exp 1 1234 0",
        c_we, c_wd, stall);
    end
    step();
    n_chk++;
    if (ld_v1 !== 1 || ld_data1 !== 32'h1234 || ld_v0 !== 0) begin
      n_fail++;
      $display("FAIL fwd_data: got %b %h v0=%b exp 1 1234 0",
        ld_v1, ld_data1, ld_v0);
    end
    idle_in();
    step();
  endtask

  task automatic test_store_store();
    set_req(1, 1, 32'h80, 32'h11, 1, 1, 32'h80, 32'h22);
    set_resp(1, 0, 1, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (c_we !== 0 || c_we2 !== 1 || c_wd2 !== 32'h22 ||
        c_addr2 !== 32'h80 || stall !== 0) begin
      n_fail++;
      $display("FAIL ss: got we=%b we2=%b wd2=%h st=%b exp 0 1 22 0",
        c_we, c_we2, c_wd2, stall);
    end
    step();
    idle_in();
    step();
  endtask

  task automatic test_load_store();
    set_req(1, 0, 32'h60, 0, 1, 1, 32'h60, 32'h77);
    set_resp(1, 0, 1, 0, 0, 32'h55, 0);
    #1;
    n_chk++;
    if (c_re !== 1 || c_we2 !== 1 || c_wd2 !== 32'h77) begin
      n_fail++;
      $display("FAIL ls_issue: got re=%b we2=%b wd2=%h exp 1 1 77",
        c_re, c_we2, c_wd2);
    end
    step();
    n_chk++;
    if (ld_v0 !== 1 || ld_data0 !== 32'h55 || ld_v1 !== 0) begin
      n_fail++;
      $display("FAIL ls_data: got %b %h %b exp 1 55 0",
        ld_v0, ld_data0, ld_v1);
    end
    idle_in();
    step();
  endtask

  task automatic test_reset_mid_refill();
    int bad;
    bad = 0;
    set_req(1, 0, 32'h700, 0, 0, 0, 0, 0);
    set_resp(0, 1, 0, 0, 0, 0, 0);
    step();
    idle_in();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_chk++;
    if (stall !== 0 || ld_v0 !== 0) begin
      n_fail++;
      $display("FAIL rst_refill: got st=%b v0=%b exp 0 0",
        stall, ld_v0);
    end
`ifdef MEMCTRL_PERF_EN
    n_chk++;
    if (perf_hits !== 0 || perf_misses !== 0 ||
        perf_stalls !== 0) begin
      n_fail++;
      $display("FAIL rst_perf: got %0d/%0d/%0d exp 0",
        perf_hits, perf_misses, perf_stalls);
    end
`endif
    for (int c = 0; c < 12; c++) begin
      if (stall || ld_v0 || ld_v1) bad++;
      step();
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rst_no_replay: got %0d busy cycles exp 0", bad);
    end
  endtask

  task automatic test_random_back_to_back();
    for (int n = 0; n < 40; n++) begin
      logic v0, we0, v1, we1, ms0, ms1, d1, d2, rem, m, iss;
      logic ev0, ev1;
      logic [31:0] a0, a1, w0, w1, rd0, rd1, j;
      int l1, l2, total, last;
      v0 = 1'($urandom % 2);  we0 = 1'($urandom % 2);
      v1 = 1'($urandom % 2);  we1 = 1'($urandom % 2);
      a0 = 32'h1000 + ($urandom % 64) * 4;
      a1 = 32'h2000 + ($urandom % 64) * 4;
      w0 = $urandom;  w1 = $urandom;
      rd0 = $urandom; rd1 = $urandom;
      ms0 = ($urandom % 4) == 0;
      ms1 = ($urandom % 4) == 0;
      d1 = 1'($urandom % 2);  d2 = 1'($urandom % 2);
      m = (v0 && ms0) || (v1 && ms1);
      rem = m && (($urandom % 3) == 0);
      l1 = MISS_LAT + (d1 ? WB_PEN : 0);
      l2 = MISS_LAT + (d2 ? WB_PEN : 0);
      total = m ? 2 + l1 + (rem ? 1 + l2 : 0) : 1;
      last = total - 1;
      for (int c = 0; c < total; c++) begin
        j = $urandom;
        if (c == 0) begin
          set_req(v0, we0, a0, w0, v1, we1, a1, w1);
          set_resp(!ms0, ms0, !ms1, ms1, d1, rd0, rd1);
        end else begin
          set_req(j[0], j[1], $urandom, $urandom,
                  j[2], j[3], $urandom, $urandom);
          if (rem && c == 1 + l1)
            set_resp(!v0, v0, v0, !v0, d2, j, j);
          else if (c == last)
            set_resp(1, 0, 1, 0, j[4], rd0, rd1);
          else
            set_resp(j[5], j[6], j[7], j[8], j[9], j, j);
        end
        #1;
        iss = (c == 0) || (m && (c == 1 + l1 || c == last));
        n_chk++;
        if (stall !== m) begin
          n_fail++;
          $display("FAIL rnd_stall: n=%0d c=%0d got %b exp %b",
            n, c, stall, m);
        end
        n_chk++;
        if ({c_re, c_we, c_re2, c_we2} !==
            (iss ? {v0 && !we0, v0 && we0, v1 && !we1, v1 && we1}
                 : 4'b0) ||
            (iss && v0 && (c_addr !== a0 || c_wd !== w0)) ||
            (iss && v1 && (c_addr2 !== a1 || c_wd2 !== w1))) begin
          n_fail++;
          $display("FAIL rnd_issue: n=%0d c=%0d got %b %h %h exp %b %h %h",
            n, c, {c_re, c_we, c_re2, c_we2}, c_addr, c_addr2,
            {v0 && !we0, v0 && we0, v1 && !we1, v1 && we1} & {4{iss}},
            a0, a1);
        end
        step();
        ev0 = (c == last) && v0 && !we0;
        ev1 = (c == last) && v1 && !we1;
        n_chk++;
        if (ld_v0 !== ev0 || ld_v1 !== ev1 ||
            (ev0 && ld_data0 !== rd0) ||
            (ev1 && ld_data1 !== rd1)) begin
          n_fail++;
          $display("FAIL rnd_ld: n=%0d c=%0d got %b%b %h %h exp %b%b %h %h",
            n, c, ld_v0, ld_v1, ld_data0, ld_data1,
            ev0, ev1, rd0, rd1);
        end
      end
    end
    idle_in();
    step();
  endtask

  initial begin
    test_reset();
    test_two_loads_hit();
    test_load_miss_clean();
    test_dirty_lane1();
    test_fwd();
    test_store_store();
    test_load_store();
    test_reset_mid_refill();
    test_random_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
